// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic parametrised pipeline stage register for any stage
//               boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries an opaque
//               payload and a control vector, plus a valid bit, stall hold,
//               flush and bubble insertion. A per-bit kill mask selects which
//               control bits are forced to zero when a bubble is created.
//               State updates on the falling edge of Clk.
// Optional    : PIPE_PERF_EN - when defined, saturating stall and bubble
//               performance counters (and perf_clr) are implemented. When
//               undefined, both counter outputs are tied to zero and perf_clr
//               is ignored.
// Ports       :
//   Clk             in   1      stage clock (negative-edge active)
//   Clrn            in   1      asynchronous active-low reset
//   stall           in   1      hold current contents
//   flush           in   1      squash the stage (beats stall)
//   bubble          in   1      insert a NOP instead of the incoming instr
//   in_valid        in   1      incoming instruction valid
//   in_data         in   DW     incoming payload
//   in_ctrl         in   CW     incoming control vector
//   perf_clr        in   1      synchronous clear of perf counters
//   out_valid       out  1      stage holds a valid instruction
//   out_data        out  DW     registered payload
//   out_ctrl        out  CW     registered control vector
//   out_bubble      out  1      current contents are an inserted bubble
//   perf_stall_cnt  out  CNT_W  saturating count of stalled edges
//   perf_bubble_cnt out  CNT_W  saturating count of inserted bubbles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int          DW        = 160,
  parameter int          CW        = 11,
  parameter logic [CW-1:0] KILL_MASK = {CW{1'b1}},
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             stall,
  input  logic             flush,
  input  logic             bubble,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  input  logic             perf_clr,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl,
  output logic             out_bubble,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt
);

  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic [CW-1:0]   r_ctrl;
  logic            r_bubble;

  // Control vector with killable bits cleared; unmasked bits pass through so
  // downstream datapath muxes keep a deterministic select during a bubble.
  logic [CW-1:0]   w_kill_ctrl;
  // An invalid incoming instruction is handled exactly like a bubble.
  logic            w_take_bubble;
  // Edge classification used by the performance counters.
  logic            w_stall_evt;
  logic            w_bubble_evt;

  assign w_kill_ctrl   = in_ctrl & ~KILL_MASK;
  assign w_take_bubble = bubble | ~in_valid;
  assign w_stall_evt   = ~flush & stall;
  assign w_bubble_evt  = flush | (~stall & w_take_bubble);

  // Priority: reset > flush > stall > bubble/invalid > load.
  always_ff @(negedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ctrl   <= '0;
      r_bubble <= 1'b0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_data   <= in_data;
      r_ctrl   <= w_kill_ctrl;
      r_bubble <= 1'b1;
    end else if (!stall) begin
      r_data <= in_data;
      if (w_take_bubble) begin
        r_valid  <= 1'b0;
        r_ctrl   <= w_kill_ctrl;
        r_bubble <= 1'b1;
      end else begin
        r_valid  <= 1'b1;
        r_ctrl   <= in_ctrl;
        r_bubble <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_ctrl   = r_ctrl;
  assign out_bubble = r_bubble;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Counters saturate at all-ones; a clear on the same edge wins.
  always_ff @(negedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_bubble_evt && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`else
  // Counters compiled out; keep the clear input and event terms referenced.
  logic w_unused_perf;
  assign w_unused_perf   = perf_clr ^ w_stall_evt ^ w_bubble_evt;
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule
`default_nettype wire
